router_out_arbiter: RTL and testbench

Arbitration and sequencing block in front of the router's output ports. It accepts byte beats from input ports A and B, each tagged with a destination address. Per output it resolves contention with a per-output round-robin or fixed-priority arbiter and holds the winner in a one-entry output register until the downstream sink takes it. A 32-bit control word written over the router control interface enables the block, selects the arbitration mode and masks outputs; beats to masked or out-of-range outputs are dropped and counted.

---
 rtl/router_arb_pkg.sv | 22 ++
 rtl/router_rr_arb2.sv | 45 ++++
 rtl/router_out_arbiter.sv | 124 ++++++++++++
 tb/tb_router_out_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/router_arb_pkg.sv
// Shared definitions for the router output arbiter: control word layout,
// source encoding and the saturating drop-counter helper.
package router_arb_pkg;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_MODE     = 1;
  localparam int unsigned CTRL_PRI_B    = 2;
  localparam int unsigned CTRL_MASK_LSB = 8;

  localparam int unsigned DROP_CNT_W = 16;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  // Add 0..2 to the drop count, clamping at all-ones.
  function automatic logic [DROP_CNT_W-1:0] sat_add2(input logic [DROP_CNT_W-1:0] cnt,
                                                     input logic [1:0]            inc);
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_CNT_W - 1){1'b0}}, inc};
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/router_rr_arb2.sv
// Two-requester arbiter for one output: round-robin or fixed priority.
// The round-robin pointer moves to the loser whenever a grant is taken.
module router_rr_arb2
  import router_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_mode,
  input  logic i_pri_b,
  input  logic i_take,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  src_e r_ptr;
  logic w_b_wins;

  // Pick the winner; a lone requester always wins.
  always_comb begin
    w_b_wins = 1'b0;
    if (i_req_b) begin
      if (!i_req_a) begin
        w_b_wins = 1'b1;
      end else if (i_mode) begin
        w_b_wins = i_pri_b;
      end else begin
        w_b_wins = (r_ptr == SRC_B);
      end
    end
    o_gnt_b = w_b_wins;
    o_gnt_a = i_req_a & ~w_b_wins;
  end

  // Point at the loser of each taken grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= SRC_A;
    end else if (i_take) begin
      r_ptr <= w_b_wins ? SRC_A : SRC_B;
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-side arbiter: decodes beat targets from ports A/B, drops masked or
// out-of-range beats, arbitrates per output and holds one beat per output.
module router_out_arbiter
  import router_arb_pkg::*;
#(
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ctrl_wr,
  input  logic [31:0]               ctrl_wdata,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [DATA_W-1:0]         a_data,
  input  logic [ADDR_W-1:0]         a_addr,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [DATA_W-1:0]         b_data,
  input  logic [ADDR_W-1:0]         b_addr,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_src,
  output logic [DROP_CNT_W-1:0]     drop_cnt,
  output logic [31:0]               ctrl_q
);

  localparam int unsigned AW = $clog2(NUM_OUT);

  logic [31:0]             r_ctrl;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic [NUM_OUT-1:0]      r_out_valid;
  logic [NUM_OUT-1:0]      r_out_src;
  logic [DATA_W-1:0]       r_out_data [NUM_OUT];

  logic                    w_en;
  logic [NUM_OUT-1:0]      w_mask;
  logic [AW-1:0]           w_a_tgt, w_b_tgt;
  logic                    w_a_hit, w_b_hit;
  logic                    w_a_drop, w_b_drop;
  logic                    w_a_req, w_b_req;
  logic [NUM_OUT-1:0]      w_req_a, w_req_b, w_gnt_a, w_gnt_b;
  logic [NUM_OUT-1:0]      w_can_load, w_load_a, w_load_b;

  assign w_en    = r_ctrl[CTRL_EN];
  assign w_mask  = r_ctrl[CTRL_MASK_LSB +: NUM_OUT];
  assign w_a_tgt = a_addr[AW-1:0];
  assign w_b_tgt = b_addr[AW-1:0];

  // A beat hits a live output only if in range and not masked.
  assign w_a_hit  = (a_addr < ADDR_W'(NUM_OUT)) && w_mask[w_a_tgt];
  assign w_b_hit  = (b_addr < ADDR_W'(NUM_OUT)) && w_mask[w_b_tgt];
  assign w_a_drop = w_en & a_valid & ~w_a_hit;
  assign w_b_drop = w_en & b_valid & ~w_b_hit;
  assign w_a_req  = w_en & a_valid & w_a_hit;
  assign w_b_req  = w_en & b_valid & w_b_hit;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign w_req_a[g]    = w_a_req & (w_a_tgt == AW'(g));
    assign w_req_b[g]    = w_b_req & (w_b_tgt == AW'(g));
    // A draining slot may reload in the same cycle.
    assign w_can_load[g] = ~r_out_valid[g] | out_ready[g];
    assign w_load_a[g]   = w_gnt_a[g] & w_can_load[g];
    assign w_load_b[g]   = w_gnt_b[g] & w_can_load[g];

    router_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .i_req_a (w_req_a[g]),
      .i_req_b (w_req_b[g]),
      .i_mode  (r_ctrl[CTRL_MODE]),
      .i_pri_b (r_ctrl[CTRL_PRI_B]),
      .i_take  (w_load_a[g] | w_load_b[g]),
      .o_gnt_a (w_gnt_a[g]),
      .o_gnt_b (w_gnt_b[g])
    );

    assign out_data[g*DATA_W +: DATA_W] = r_out_data[g];
  end

  assign a_ready   = w_a_drop | (|w_load_a);
  assign b_ready   = w_b_drop | (|w_load_b);
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;
  assign drop_cnt  = r_drop_cnt;
  assign ctrl_q    = r_ctrl;

  // Control word register and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (ctrl_wr) begin
        r_ctrl <= ctrl_wdata;
      end
      r_drop_cnt <= sat_add2(r_drop_cnt, {1'b0, w_a_drop} + {1'b0, w_b_drop});
    end
  end

  // Per-output one-entry holding registers (EMPTY/FULL tracked by valid).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= '0;
      r_out_src   <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        r_out_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_load_a[i] | w_load_b[i]) begin
          r_out_valid[i] <= 1'b1;
          r_out_data[i]  <= w_load_b[i] ? b_data : a_data;
          r_out_src[i]   <= w_load_b[i];
        end else if (out_ready[i]) begin
          r_out_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter with hand-computed expectations.
module tb_router_out_arbiter;

  logic        clk;
  logic        rst;
  logic        ctrl_wr;
  logic [31:0] ctrl_wdata;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [7:0]  a_data, b_data, a_addr, b_addr;
  logic [3:0]  out_valid, out_ready, out_src;
  logic [31:0] out_data;
  logic [15:0] drop_cnt;
  logic [31:0] ctrl_q;

  int n_checks = 0;
  int n_pass   = 0;

  router_out_arbiter #(
    .NUM_OUT (4),
    .DATA_W  (8),
    .ADDR_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_wr    (ctrl_wr),
    .ctrl_wdata (ctrl_wdata),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_data     (a_data),
    .a_addr     (a_addr),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_data     (b_data),
    .b_addr     (b_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .drop_cnt   (drop_cnt),
    .ctrl_q     (ctrl_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_ctrl(input logic [31:0] w);
    ctrl_wr    = 1'b1;
    ctrl_wdata = w;
    step();
    ctrl_wr    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctrl_wr = 1'b0; ctrl_wdata = '0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; a_addr = '0; b_addr = '0;
    out_ready = 4'b1111;
    repeat (2) step();

    // Reset state, then first accept after the control write lands.
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 8'd2; a_data = 8'h5A;
    ctrl_wr = 1'b1; ctrl_wdata = 32'h0F01;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("rst_ctrl_q", ctrl_q, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("a_ready_pre_ctrl", 32'(a_ready), 32'h0);
    step();
    ctrl_wr = 1'b0;
    #1;
    chk("ctrl_q_written", ctrl_q, 32'h0F01);
    chk("a_ready_post_ctrl", 32'(a_ready), 32'h1);
    chk("out_valid_not_yet", 32'(out_valid), 32'h0);
    step();
    a_valid = 1'b0;
    chk("first_valid", 32'(out_valid), 32'h4);
    chk("first_data", 32'(out_data[23:16]), 32'h5A);
    chk("first_src", 32'(out_src), 32'h0);
    step();

    // Round-robin contention on output 1.
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 8'd1; b_addr = 8'd1;
    for (int k = 0; k < 6; k++) begin
      a_data = 8'h10 + 8'(k);
      b_data = 8'h20 + 8'(k);
      #1;
      chk("rr_a_ready", 32'(a_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_b_ready", 32'(b_ready), (k % 2 == 0) ? 32'h0 : 32'h1);
      step();
      chk("rr_src1", 32'(out_src[1]), (k % 2 == 0) ? 32'h0 : 32'h1);
      chk("rr_data1", 32'(out_data[15:8]), (k % 2 == 0) ? 32'(8'h10 + k) : 32'(8'h20 + k));
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // Fixed priority, B wins.
    wr_ctrl(32'h0F07);
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 8'd0; b_addr = 8'd0;
    for (int k = 0; k < 4; k++) begin
      a_data = 8'h30 + 8'(k);
      b_data = 8'h40 + 8'(k);
      #1;
      chk("fix_a_ready", 32'(a_ready), 32'h0);
      chk("fix_b_ready", 32'(b_ready), 32'h1);
      step();
      chk("fix_src0", 32'(out_src[0]), 32'h1);
      chk("fix_data0", 32'(out_data[7:0]), 32'(8'h40 + k));
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Out-of-range and masked beats dropped together.
    wr_ctrl(32'h0701);
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 8'd7; b_addr = 8'd3;
    #1;
    chk("drop_a_ready", 32'(a_ready), 32'h1);
    chk("drop_b_ready", 32'(b_ready), 32'h1);
    chk("drop_cnt_pre", 32'(drop_cnt), 32'h0);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("drop_cnt_post", 32'(drop_cnt), 32'h2);
    chk("drop_no_valid", 32'(out_valid), 32'h0);

    // Backpressure on output 2, then same-cycle drain and reload.
    wr_ctrl(32'h0F01);
    out_ready = 4'b1011;
    a_valid = 1'b1; a_addr = 8'd2; a_data = 8'h77;
    step();
    chk("bp_fill_valid", 32'(out_valid), 32'h4);
    chk("bp_fill_data", 32'(out_data[23:16]), 32'h77);
    a_data = 8'h88;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_a_ready", 32'(a_ready), 32'h0);
      step();
      chk("bp_hold_data", 32'(out_data[23:16]), 32'h77);
      chk("bp_hold_valid", 32'(out_valid), 32'h4);
    end
    out_ready = 4'b1111;
    #1;
    chk("bp_reload_ready", 32'(a_ready), 32'h1);
    step();
    a_valid = 1'b0;
    chk("bp_reload_valid", 32'(out_valid), 32'h4);
    chk("bp_reload_data", 32'(out_data[23:16]), 32'h88);
    step();

    // Build up out_valid=1011 and drop_cnt=5, then reset.
    out_ready = 4'b0000;
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = 8'd0; a_data = 8'h01; b_addr = 8'd1; b_data = 8'h02;
    step();
    a_addr = 8'd3; a_data = 8'h03; b_addr = 8'd9;
    step();
    a_addr = 8'd7; b_addr = 8'd8;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'hB);
    chk("pre_rst_drops", 32'(drop_cnt), 32'h5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_drops", 32'(drop_cnt), 32'h0);
    chk("mid_rst_ctrl", ctrl_q, 32'h0);
    out_ready = 4'b1111;

    // Drive the drop counter to saturation, two drops per cycle.
    wr_ctrl(32'h0F01);
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 8'd7; b_addr = 8'd7;
    repeat (32766) @(posedge clk);
    #1;
    chk("sat_fffc", 32'(drop_cnt), 32'hFFFC);
    step();
    chk("sat_fffe", 32'(drop_cnt), 32'hFFFE);
    step();
    chk("sat_ffff", 32'(drop_cnt), 32'hFFFF);
    step();
    chk("sat_hold", 32'(drop_cnt), 32'hFFFF);
    a_valid = 1'b0; b_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
